dmem_access_ctrl: RTL and testbench

Load/store initiator sitting between the CPU execute stage and the `data_mem` block. It accepts one load or store request at a time from the pipeline and translates it into the exact `data_mem` access sequence. That sequence is an address-latch cycle (`wren`=1), then either a write cycle (`wren`=0) or a read-capture cycle. The block returns load data, a done pulse and an error flag for misaligned or out-of-range addresses.

---
 rtl/dmem_access_ctrl.sv | 107 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator between the execute stage and data_mem: turns one request
// into an address-latch cycle followed by a write or read-capture cycle.
module dmem_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              dm_wren,
    output logic              dm_is_load,
    output logic              dm_is_store,
    output logic [ADDR_W-1:0] dm_r_addr,
    output logic [ADDR_W-1:0] dm_w_addr,
    output logic [DATA_W-1:0] dm_w_data,
    input  logic [DATA_W-1:0] dm_r_data
);

    typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              load_q, store_q, err_q;
    logic              accept, bad_req;

    assign accept  = (state == IDLE) && req_valid && (req_is_load || req_is_store);
    // Rejected: ambiguous op, misaligned, or beyond the 2^ADDR_W word window.
    assign bad_req = (req_is_load && req_is_store) || (req_addr[1:0] != 2'b00)
                   || (|req_addr[31:ADDR_W+2]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                load_q  <= req_is_load;
                store_q <= req_is_store;
                err_q   <= bad_req;
            end
            if (state == READ) rdata <= dm_r_data;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        dm_wren     = 1'b1;
        dm_is_load  = 1'b0;
        dm_is_store = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_next = bad_req ? DONE : ADDR;
            end
            ADDR: begin
                dm_is_load  = load_q;
                dm_is_store = store_q;
                state_next  = store_q ? WRITE : READ;
            end
            WRITE: begin
                // Reset overrides the write strobe so a reset never commits data.
                dm_wren     = rst;
                dm_is_store = 1'b1;
                state_next  = DONE;
            end
            READ: begin
                dm_is_load = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dm_r_addr = addr_q;
    assign dm_w_addr = addr_q;
    assign dm_w_data = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural data_mem model
// (address latched when wren=1, word written when wren=0).
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_load, req_is_store;
    logic [31:0] req_addr, req_wdata;
    logic        done, err;
    logic [31:0] rdata;
    logic        dm_wren, dm_is_load, dm_is_store;
    logic [4:0]  dm_r_addr, dm_w_addr;
    logic [31:0] dm_w_data, dm_r_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .rdata(rdata),
        .dm_wren(dm_wren), .dm_is_load(dm_is_load), .dm_is_store(dm_is_store),
        .dm_r_addr(dm_r_addr), .dm_w_addr(dm_w_addr),
        .dm_w_data(dm_w_data), .dm_r_data(dm_r_data)
    );

    // data_mem model; word i initially holds 0x1000_0000 + i
    logic [31:0] mem [32];
    logic [4:0]  lat_addr = 5'd0;
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
            mem_init <= 1'b1;
        end else if (dm_wren) begin
            lat_addr <= dm_r_addr;
        end else begin
            mem[lat_addr] <= dm_w_data;
        end
    end

    assign dm_r_data = mem[lat_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let it be accepted at the next edge, then scramble the
    // request inputs to show they are only sampled at accept.
    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_addr     = a;
        req_wdata    = wd;
        step();
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
        req_addr     = 32'h0000_0004;
        req_wdata    = 32'h0BAD_0BAD;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_done",  32'(done),      32'd0);
            check("rst_wren",  32'(dm_wren),   32'd1);
            check("rst_rdata", rdata,          32'd0);
        end
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_addr",  32'(dm_r_addr), 32'd0);
        check("post_rst_wdata", dm_w_data,      32'd0);
        check("post_rst_tags",  {30'd0, dm_is_load, dm_is_store}, 32'd0);

        // Store 0xDEADBEEF to byte 0x14 (word 5)
        issue(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF);
        check("st_addr_wren",  32'(dm_wren),     32'd1);
        check("st_addr_raddr", 32'(dm_r_addr),   32'd5);
        check("st_addr_waddr", 32'(dm_w_addr),   32'd5);
        check("st_addr_tag",   32'(dm_is_store), 32'd1);
        check("st_addr_ready", 32'(req_ready),   32'd0);
        step();
        check("st_wr_wren",  32'(dm_wren),     32'd0);
        check("st_wr_wdata", dm_w_data,        32'hDEAD_BEEF);
        check("st_wr_tag",   32'(dm_is_store), 32'd1);
        step();
        check("st_done", 32'(done),    32'd1);
        check("st_err",  32'(err),     32'd0);
        check("st_dwr",  32'(dm_wren), 32'd1);
        check("st_dtag", {30'd0, dm_is_load, dm_is_store}, 32'd0);
        step();
        check("st_idle_ready", 32'(req_ready), 32'd1);
        check("st_idle_done",  32'(done),      32'd0);
        check("st_idle_addr",  32'(dm_r_addr), 32'd5);

        // Load back word 5
        issue(1'b1, 1'b0, 32'h14, 32'h0);
        check("ld_addr_tag",  32'(dm_is_load), 32'd1);
        check("ld_addr_wren", 32'(dm_wren),    32'd1);
        step();
        check("ld_rd_wren", 32'(dm_wren),    32'd1);
        check("ld_rd_tag",  32'(dm_is_load), 32'd1);
        step();
        check("ld_done",  32'(done), 32'd1);
        check("ld_err",   32'(err),  32'd0);
        check("ld_rdata", rdata,     32'hDEAD_BEEF);
        step();

        // Store to 0x18 must not disturb rdata
        issue(1'b0, 1'b1, 32'h18, 32'h1234_5678);
        step();
        step();
        check("st2_done",  32'(done), 32'd1);
        check("st2_rdata", rdata,     32'hDEAD_BEEF);
        step();

        // Error requests: misaligned, out of range, both op bits
        issue(1'b1, 1'b0, 32'h16, 32'h0);
        check("mis_done",  32'(done),    32'd1);
        check("mis_err",   32'(err),     32'd1);
        check("mis_wren",  32'(dm_wren), 32'd1);
        check("mis_rdata", rdata,        32'hDEAD_BEEF);
        step();
        check("mis_idle", 32'(req_ready), 32'd1);

        issue(1'b0, 1'b1, 32'h80, 32'hFFFF_FFFF);
        check("oor_done",  32'(done),    32'd1);
        check("oor_err",   32'(err),     32'd1);
        check("oor_wren",  32'(dm_wren), 32'd1);
        check("oor_tags",  {30'd0, dm_is_load, dm_is_store}, 32'd0);
        step();
        check("oor_idle", 32'(req_ready), 32'd1);

        issue(1'b1, 1'b1, 32'h14, 32'h0);
        check("both_done",  32'(done),    32'd1);
        check("both_err",   32'(err),     32'd1);
        check("both_wren",  32'(dm_wren), 32'd1);
        check("both_rdata", rdata,        32'hDEAD_BEEF);
        step();

        // Valid with no op bits: never accepted
        req_valid = 1'b1;
        req_addr  = 32'h14;
        for (int c = 0; c < 3; c++) begin
            step();
            check("noop_ready", 32'(req_ready),  32'd1);
            check("noop_done",  32'(done),       32'd0);
            check("noop_tag",   32'(dm_is_load), 32'd0);
        end
        req_valid = 1'b0;

        // Store to 0x08 interrupted by reset in its WRITE cycle
        issue(1'b0, 1'b1, 32'h08, 32'hCAFE_F00D);
        step();
        check("rw_wren_pre", 32'(dm_wren), 32'd0);
        rst = 1'b1;
        #1;
        check("rw_wren_rst", 32'(dm_wren), 32'd1);
        step();
        rst = 1'b0;
        check("rw_idle",  32'(req_ready), 32'd1);
        check("rw_done",  32'(done),      32'd0);
        check("rw_rdata", rdata,          32'd0);
        step();
        check("rw_no_done", 32'(done), 32'd0);

        issue(1'b1, 1'b0, 32'h08, 32'h0);
        step();
        step();
        check("rw_ld_done",  32'(done), 32'd1);
        check("rw_ld_rdata", rdata,     32'h1000_0002);
        step();

        issue(1'b1, 1'b0, 32'h18, 32'h0);
        step();
        step();
        check("ld18_rdata", rdata, 32'h1234_5678);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
